// File: rtl/decoder_scan.sv
// Registered N-to-2^N active-low one-hot decoder with three enables and a
// prescaled scan mode that walks the selected output through 0..scan_last.
module decoder_scan #(
  parameter int ADDR_W   = 3,
  parameter int PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s1,
  input  logic                 s2_n,
  input  logic                 s3_n,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    a,
  input  logic [ADDR_W-1:0]    scan_last,
  output logic [2**ADDR_W-1:0] y,
  output logic [ADDR_W-1:0]    cur_ch,
  output logic                 wrap
);

  localparam int N    = 2**ADDR_W;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1);
  localparam logic [PS_W-1:0]   PS_ZERO  = {PS_W{1'b0}};
  localparam logic [ADDR_W-1:0] CH_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CH_ZERO  = {ADDR_W{1'b0}};
  localparam logic [N-1:0]      ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]      ALL_OFF  = {N{1'b1}};

  logic              en_s;
  logic [ADDR_W-1:0] ch_nxt_s;
  logic [PS_W-1:0]   ps_nxt_s;
  logic              wrap_nxt_s;
  logic [N-1:0]      y_nxt_s;

  logic [ADDR_W-1:0] cur_ch_r;
  logic [PS_W-1:0]   ps_r;
  logic              wrap_r;
  logic [N-1:0]      y_r;

  // Next channel, prescaler, wrap pulse and decoded select
  always_comb begin
    en_s       = s1 & ~s2_n & ~s3_n;
    ch_nxt_s   = cur_ch_r;
    ps_nxt_s   = ps_r;
    wrap_nxt_s = 1'b0;
    y_nxt_s    = ALL_OFF;

    if (!mode) begin
      ch_nxt_s = a;
      ps_nxt_s = PS_ZERO;
    end else if (en_s) begin
      if (ps_r == PS_LAST) begin
        ps_nxt_s = PS_ZERO;
        // Wrap is tested before incrementing, so the channel never overflows
        // and a lowered scan_last pulls an out-of-range channel back to 0.
        if (cur_ch_r >= scan_last) begin
          ch_nxt_s   = CH_ZERO;
          wrap_nxt_s = 1'b1;
        end else begin
          ch_nxt_s = cur_ch_r + CH_ONE;
        end
      end else begin
        ps_nxt_s = ps_r + PS_ONE;
      end
    end else begin
      ch_nxt_s = cur_ch_r;
      ps_nxt_s = ps_r;
    end

    if (en_s) begin
      y_nxt_s = ~(ONE_HOT0 << ch_nxt_s);
    end else begin
      y_nxt_s = ALL_OFF;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_r <= CH_ZERO;
      ps_r     <= PS_ZERO;
      wrap_r   <= 1'b0;
      y_r      <= ALL_OFF;
    end else begin
      cur_ch_r <= ch_nxt_s;
      ps_r     <= ps_nxt_s;
      wrap_r   <= wrap_nxt_s;
      y_r      <= y_nxt_s;
    end
  end

  assign y      = y_r;
  assign cur_ch = cur_ch_r;
  assign wrap   = wrap_r;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: stimulus pushes expected outputs, a
// monitor pops and compares one entry per clock for each DUT instance.
module tb_decoder_scan;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] ch;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s1, s2_n, s3_n, mode;
  logic [2:0] a, scan_last;
  logic [7:0] y4, y1;
  logic [2:0] ch4, ch1;
  logic       w4, w1;

  exp_t q4[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  decoder_scan #(.ADDR_W(3), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2_n(s2_n), .s3_n(s3_n), .mode(mode),
    .a(a), .scan_last(scan_last), .y(y4), .cur_ch(ch4), .wrap(w4));

  decoder_scan #(.ADDR_W(3), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2_n(s2_n), .s3_n(s3_n), .mode(mode),
    .a(a), .scan_last(scan_last), .y(y1), .cur_ch(ch1), .wrap(w1));

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one sample per clock, 1 time unit after the rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp("p4_y", y4, e.y);
      cmp("p4_cur_ch", {5'd0, ch4}, {5'd0, e.ch});
      cmp("p4_wrap", {7'd0, w4}, {7'd0, e.w});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("p1_y", y1, e.y);
      cmp("p1_cur_ch", {5'd0, ch1}, {5'd0, e.ch});
      cmp("p1_wrap", {7'd0, w1}, {7'd0, e.w});
    end
  end

  function automatic logic [7:0] dec(input logic [2:0] ch);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << ch);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic e4(input logic [7:0] ey, input logic [2:0] ech, input logic ew);
    exp_t e;
    e.y = ey; e.ch = ech; e.w = ew;
    q4.push_back(e);
    step();
  endtask

  task automatic e1(input logic [7:0] ey, input logic [2:0] ech, input logic ew);
    exp_t e;
    e.y = ey; e.ch = ech; e.w = ew;
    q1.push_back(e);
    step();
  endtask

  logic [7:0] dir_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s1 = 1'b0; s2_n = 1'b1; s3_n = 1'b1; mode = 1'b0; a = 3'd0; scan_last = 3'd0;

    // Reset held with random inputs and a running clock
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {s1, s2_n, s3_n, mode} = 4'($urandom_range(0, 15));
      a = 3'($urandom_range(0, 7));
      scan_last = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    cmp("rst_y", y4, 8'hFF);
    cmp("rst_cur_ch", {5'd0, ch4}, 8'd0);
    cmp("rst_wrap", {7'd0, w4}, 8'd0);
    cmp("rst_y_p1", y1, 8'hFF);

    s1 = 1'b1; s2_n = 1'b0; s3_n = 1'b0; mode = 1'b0; a = 3'd0; scan_last = 3'd5;
    rst_n = 1'b1;

    // Direct decode sweep
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      e4(dir_tab[i], 3'(i), 1'b0);
    end

    // Enable gating at a=3
    a = 3'd3;
    for (int i = 0; i < 8; i++) begin
      {s1, s2_n, s3_n} = 3'(i);
      e4((i == 4) ? 8'hF7 : 8'hFF, 3'd3, 1'b0);
    end
    // Disabled direct mode still tracks a
    s1 = 1'b0; s2_n = 1'b0; s3_n = 1'b0; a = 3'd2;
    e4(8'hFF, 3'd2, 1'b0);

    // Scan 0..5 with PRESCALE=4
    s1 = 1'b1; a = 3'd0; scan_last = 3'd5;
    e4(8'hFE, 3'd0, 1'b0);
    mode = 1'b1;
    for (int k = 0; k < 3; k++) e4(8'hFE, 3'd0, 1'b0);
    for (int s = 1; s <= 6; s++) begin
      for (int k = 0; k < 4; k++) begin
        e4(dec(3'(s % 6)), 3'(s % 6), (s == 6 && k == 0) ? 1'b1 : 1'b0);
      end
    end
    // Now ch0 with prescaler at 3: walk to ch2, prescaler 1
    for (int k = 0; k < 4; k++) e4(8'hFD, 3'd1, 1'b0);
    e4(8'hFB, 3'd2, 1'b0);
    e4(8'hFB, 3'd2, 1'b0);

    // Disable for 10 cycles mid-prescale
    s1 = 1'b0;
    for (int k = 0; k < 10; k++) e4(8'hFF, 3'd2, 1'b0);
    s1 = 1'b1;
    e4(8'hFB, 3'd2, 1'b0);
    e4(8'hFB, 3'd2, 1'b0);
    for (int k = 0; k < 4; k++) e4(8'hF7, 3'd3, 1'b0);
    e4(8'hEF, 3'd4, 1'b0);

    // Lower scan_last below cur_ch
    scan_last = 3'd1;
    for (int k = 0; k < 3; k++) e4(8'hEF, 3'd4, 1'b0);
    e4(8'hFE, 3'd0, 1'b1);
    for (int k = 0; k < 3; k++) e4(8'hFE, 3'd0, 1'b0);

    // Enable drops exactly on a scheduled step, step taken on return
    s1 = 1'b0;
    e4(8'hFF, 3'd0, 1'b0);
    s1 = 1'b1;
    e4(8'hFD, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) e4(8'hFD, 3'd1, 1'b0);
    e4(8'hFE, 3'd0, 1'b1);

    // Mode switch: start scan from a=6, full range
    mode = 1'b0; a = 3'd6;
    e4(8'hBF, 3'd6, 1'b0);
    mode = 1'b1; scan_last = 3'd7;
    for (int k = 0; k < 3; k++) e4(8'hBF, 3'd6, 1'b0);
    for (int k = 0; k < 4; k++) e4(8'h7F, 3'd7, 1'b0);
    e4(8'hFE, 3'd0, 1'b1);
    e4(8'hFE, 3'd0, 1'b0);
    mode = 1'b0; a = 3'd5;
    e4(8'hDF, 3'd5, 1'b0);

    // PRESCALE=1 instance: advance every enabled cycle
    a = 3'd0; scan_last = 3'd5;
    e1(8'hFE, 3'd0, 1'b0);
    mode = 1'b1;
    for (int s = 1; s <= 7; s++) e1(dec(3'(s % 6)), 3'(s % 6), (s == 6) ? 1'b1 : 1'b0);
    scan_last = 3'd0;
    for (int k = 0; k < 3; k++) e1(8'hFE, 3'd0, 1'b1);

    // Asynchronous reset between clock edges mid-scan
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_y", y4, 8'hFF);
    cmp("async_rst_cur_ch", {5'd0, ch4}, 8'd0);
    cmp("async_rst_wrap", {7'd0, w4}, 8'd0);
    cmp("async_rst_y_p1", y1, 8'hFF);
    cmp("queues_drained", 8'(q4.size() + q1.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
